// File: rtl/debug_controller_bp.sv
// UART debug controller: loads instruction memory, runs/steps the processor with a breakpoint,
// and streams PC, data memory, register bank and cycle count back as LSB-first bytes.
module debug_controller_bp #(
  parameter int NBITS          = 32,
  parameter int UART_BITS      = 8,
  parameter int IM_ADDR_LENGTH = 32,
  parameter int IM_DEPTH       = 32,
  parameter int DM_ADDR_LENGTH = 32,
  parameter int DM_WORDS       = 4,
  parameter int RBITS          = 5,
  parameter int RB_REGS        = 32,
  parameter logic [NBITS-1:0] HALT_WORD  = 32'hFFFFFFFF,
  parameter logic [NBITS-1:0] CMD_RUN    = 32'h1,
  parameter logic [NBITS-1:0] CMD_STEP   = 32'h2,
  parameter logic [NBITS-1:0] CMD_BP     = 32'h3,
  parameter logic [NBITS-1:0] CMD_RELOAD = 32'h4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [UART_BITS-1:0]      rx_data,
  input  logic                      rx_done,
  input  logic                      tx_done,
  input  logic                      halt_flag,
  input  logic [NBITS-1:0]          current_PC,
  input  logic [NBITS-1:0]          clock_count,
  input  logic [NBITS-1:0]          DM_Data,
  input  logic [NBITS-1:0]          RB_Data,
  output logic [UART_BITS-1:0]      tx_data,
  output logic                      tx_start,
  output logic [IM_ADDR_LENGTH-1:0] IM_Addr,
  output logic [NBITS-1:0]          IM_Data,
  output logic                      IM_We,
  output logic [DM_ADDR_LENGTH-1:0] DM_Addr,
  output logic [RBITS-1:0]          RB_Addr,
  output logic                      clock_enable,
  output logic                      o_rst
);
  localparam int NBYTES = NBITS / UART_BITS;
  localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int IDX_W  = $clog2(IM_DEPTH + 1);
  localparam int DI_MAX = (DM_WORDS > RB_REGS) ? DM_WORDS : RB_REGS;
  localparam int DI_W   = (DI_MAX > 1) ? $clog2(DI_MAX) : 1;
  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0] IM_FULL   = IDX_W'(IM_DEPTH);
  localparam logic [DI_W-1:0]  DM_LAST   = DI_W'(DM_WORDS - 1);
  localparam logic [DI_W-1:0]  RB_LAST   = DI_W'(RB_REGS - 1);

  typedef enum logic [3:0] {
    RECV_PROG, RECV_CMD, RECV_BP, RUN, STEP, DUMP_PC, DUMP_DM, DUMP_RB, DUMP_CLK
  } state_t;
  typedef enum logic [2:0] {P_SET, P_WAIT, P_LATCH, P_TX, P_TXW} phase_t;

  state_t                    state_reg, state_next;
  phase_t                    phase_reg, phase_next;
  logic [BC_W-1:0]           rx_cnt_reg, rx_cnt_next;
  logic [NBITS-1:0]          asm_word_reg, asm_word_next;
  logic [IDX_W-1:0]          index_reg, index_next;
  logic                      im_we_reg, im_we_next;
  logic [IM_ADDR_LENGTH-1:0] im_addr_reg, im_addr_next;
  logic [NBITS-1:0]          im_data_reg, im_data_next;
  logic                      o_rst_reg, o_rst_next;
  logic                      bp_en_reg, bp_en_next;
  logic [NBITS-1:0]          bp_addr_reg, bp_addr_next;
  logic                      first_cycle_reg, first_cycle_next;
  logic                      dump_halt_reg, dump_halt_next;
  logic [DI_W-1:0]           dump_idx_reg, dump_idx_next;
  logic [BC_W-1:0]           tx_cnt_reg, tx_cnt_next;
  logic [NBITS-1:0]          tx_word_reg, tx_word_next;
  logic [DM_ADDR_LENGTH-1:0] dm_addr_reg, dm_addr_next;
  logic [RBITS-1:0]          rb_addr_reg, rb_addr_next;

  logic [NBITS-1:0] rx_word;
  logic             rx_active;
  logic             word_strobe;
  logic             bp_hit;

  // Bytes shift in from the top so the first byte received ends up in the LSBs.
  assign rx_word   = {rx_data, asm_word_reg[NBITS-1:UART_BITS]};
  assign rx_active = (state_reg == RECV_PROG) || (state_reg == RECV_CMD) || (state_reg == RECV_BP);

  always_comb begin
    state_next       = state_reg;
    phase_next       = phase_reg;
    rx_cnt_next      = rx_cnt_reg;
    asm_word_next    = asm_word_reg;
    index_next       = index_reg;
    im_we_next       = 1'b0;
    im_addr_next     = im_addr_reg;
    im_data_next     = im_data_reg;
    o_rst_next       = 1'b0;
    bp_en_next       = bp_en_reg;
    bp_addr_next     = bp_addr_reg;
    first_cycle_next = 1'b0;
    dump_halt_next   = dump_halt_reg;
    dump_idx_next    = dump_idx_reg;
    tx_cnt_next      = tx_cnt_reg;
    tx_word_next     = tx_word_reg;
    dm_addr_next     = dm_addr_reg;
    rb_addr_next     = rb_addr_reg;
    clock_enable     = 1'b0;
    tx_start         = 1'b0;
    word_strobe      = 1'b0;
    bp_hit           = 1'b0;

    if (rx_active && rx_done) begin
      asm_word_next = rx_word;
      if (rx_cnt_reg == LAST_BYTE) begin
        rx_cnt_next = '0;
        word_strobe = 1'b1;
      end else begin
        rx_cnt_next = rx_cnt_reg + BC_W'(1);
      end
    end

    case (state_reg)
      RECV_PROG: begin
        if (word_strobe) begin
          if (index_reg < IM_FULL) begin
            im_we_next   = 1'b1;
            im_addr_next = IM_ADDR_LENGTH'({index_reg, 2'b00});
            im_data_next = rx_word;
            index_next   = index_reg + IDX_W'(1);
          end
          if (rx_word == HALT_WORD) state_next = RECV_CMD;
        end
      end
      RECV_CMD: begin
        if (word_strobe) begin
          case (rx_word)
            CMD_RUN: begin
              state_next       = RUN;
              first_cycle_next = 1'b1;
            end
            CMD_STEP: state_next = STEP;
            CMD_BP:   state_next = RECV_BP;
            CMD_RELOAD: begin
              o_rst_next = 1'b1;
              index_next = '0;
              state_next = RECV_PROG;
            end
            default: state_next = RECV_CMD;
          endcase
        end
      end
      RECV_BP: begin
        if (word_strobe) begin
          bp_addr_next = rx_word;
          bp_en_next   = (rx_word != HALT_WORD);
          state_next   = RECV_CMD;
        end
      end
      RUN: begin
        // The first RUN cycle ignores the breakpoint so a run can resume from it.
        bp_hit       = bp_en_reg && (current_PC == bp_addr_reg) && !first_cycle_reg;
        clock_enable = !halt_flag && !bp_hit;
        if (halt_flag || bp_hit) begin
          state_next     = DUMP_PC;
          phase_next     = P_SET;
          dump_idx_next  = '0;
          dump_halt_next = halt_flag;
        end
      end
      STEP: begin
        clock_enable   = !halt_flag;
        state_next     = DUMP_PC;
        phase_next     = P_SET;
        dump_idx_next  = '0;
        dump_halt_next = halt_flag;
      end
      DUMP_PC, DUMP_DM, DUMP_RB, DUMP_CLK: begin
        case (phase_reg)
          P_SET: begin
            if (state_reg == DUMP_PC) dump_halt_next = dump_halt_reg || halt_flag;
            if (state_reg == DUMP_DM) dm_addr_next = DM_ADDR_LENGTH'({dump_idx_reg, 2'b00});
            if (state_reg == DUMP_RB) rb_addr_next = RBITS'(dump_idx_reg);
            phase_next = P_WAIT;
          end
          P_WAIT: phase_next = P_LATCH;
          P_LATCH: begin
            case (state_reg)
              DUMP_PC: tx_word_next = current_PC;
              DUMP_DM: tx_word_next = DM_Data;
              DUMP_RB: tx_word_next = RB_Data;
              default: tx_word_next = clock_count;
            endcase
            tx_cnt_next = '0;
            phase_next  = P_TX;
          end
          P_TX: begin
            tx_start   = 1'b1;
            phase_next = P_TXW;
          end
          default: begin
            if (tx_done) begin
              if (tx_cnt_reg != LAST_BYTE) begin
                tx_cnt_next  = tx_cnt_reg + BC_W'(1);
                tx_word_next = tx_word_reg >> UART_BITS;
                phase_next   = P_TX;
              end else begin
                phase_next = P_SET;
                case (state_reg)
                  DUMP_PC: begin
                    state_next    = DUMP_DM;
                    dump_idx_next = '0;
                  end
                  DUMP_DM: begin
                    if (dump_idx_reg == DM_LAST) begin
                      state_next    = DUMP_RB;
                      dump_idx_next = '0;
                    end else begin
                      dump_idx_next = dump_idx_reg + DI_W'(1);
                    end
                  end
                  DUMP_RB: begin
                    if (dump_idx_reg == RB_LAST) begin
                      state_next    = DUMP_CLK;
                      dump_idx_next = '0;
                    end else begin
                      dump_idx_next = dump_idx_reg + DI_W'(1);
                    end
                  end
                  default: begin
                    // A halted program is restarted and a fresh program is expected.
                    if (dump_halt_reg) begin
                      o_rst_next = 1'b1;
                      index_next = '0;
                      state_next = RECV_PROG;
                    end else begin
                      state_next = RECV_CMD;
                    end
                  end
                endcase
              end
            end
          end
        endcase
      end
      default: state_next = RECV_PROG;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= RECV_PROG;
      phase_reg       <= P_SET;
      rx_cnt_reg      <= '0;
      asm_word_reg    <= '0;
      index_reg       <= '0;
      im_we_reg       <= 1'b0;
      im_addr_reg     <= '0;
      im_data_reg     <= '0;
      o_rst_reg       <= 1'b0;
      bp_en_reg       <= 1'b0;
      bp_addr_reg     <= '0;
      first_cycle_reg <= 1'b0;
      dump_halt_reg   <= 1'b0;
      dump_idx_reg    <= '0;
      tx_cnt_reg      <= '0;
      tx_word_reg     <= '0;
      dm_addr_reg     <= '0;
      rb_addr_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      phase_reg       <= phase_next;
      rx_cnt_reg      <= rx_cnt_next;
      asm_word_reg    <= asm_word_next;
      index_reg       <= index_next;
      im_we_reg       <= im_we_next;
      im_addr_reg     <= im_addr_next;
      im_data_reg     <= im_data_next;
      o_rst_reg       <= o_rst_next;
      bp_en_reg       <= bp_en_next;
      bp_addr_reg     <= bp_addr_next;
      first_cycle_reg <= first_cycle_next;
      dump_halt_reg   <= dump_halt_next;
      dump_idx_reg    <= dump_idx_next;
      tx_cnt_reg      <= tx_cnt_next;
      tx_word_reg     <= tx_word_next;
      dm_addr_reg     <= dm_addr_next;
      rb_addr_reg     <= rb_addr_next;
    end
  end

  assign tx_data = tx_word_reg[UART_BITS-1:0];
  assign IM_Addr = im_addr_reg;
  assign IM_Data = im_data_reg;
  assign IM_We   = im_we_reg;
  assign DM_Addr = dm_addr_reg;
  assign RB_Addr = rb_addr_reg;
  assign o_rst   = o_rst_reg;

endmodule

// File: tb/tb_debug_controller_bp.sv
// Bench for debug_controller_bp: a processor/memory/UART model drives the DUT while a
// scoreboard of expected IM writes and dump bytes is checked every cycle.
module tb_debug_controller_bp;
  localparam int IMD = 32;
  localparam int DMW = 4;
  localparam int RBR = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic        tx_done = 1'b0;
  logic        halt_flag = 1'b0;
  logic [31:0] current_PC = '0;
  logic [31:0] clock_count = '0;
  logic [31:0] DM_Data = '0;
  logic [31:0] RB_Data = '0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [31:0] IM_Addr;
  logic [31:0] IM_Data;
  logic        IM_We;
  logic [31:0] DM_Addr;
  logic [4:0]  RB_Addr;
  logic        clock_enable;
  logic        o_rst;

  debug_controller_bp dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
    .halt_flag(halt_flag), .current_PC(current_PC), .clock_count(clock_count),
    .DM_Data(DM_Data), .RB_Data(RB_Data), .tx_data(tx_data), .tx_start(tx_start),
    .IM_Addr(IM_Addr), .IM_Data(IM_Data), .IM_We(IM_We), .DM_Addr(DM_Addr),
    .RB_Addr(RB_Addr), .clock_enable(clock_enable), .o_rst(o_rst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Model state
  logic [63:0] im_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] dm_mem[16];
  logic [31:0] rb_mem[32];
  logic [7:0]  tx_log[256];
  int          model_idx = 0;
  int          im_cnt = 0;
  logic [31:0] last_im_addr = '0;
  logic [31:0] last_im_data = '0;
  int          tx_sent = 0;
  logic        tx_busy = 1'b0;
  logic [31:0] model_pc = '0;
  logic [31:0] halt_pc = '0;
  logic        halt_en = 1'b0;
  logic        proc_adv = 1'b0;
  int          ce_count = 0;
  int          rst_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Processor and synchronous memories
  initial begin
    logic        ce_s, rst_s;
    logic [31:0] dma_s;
    logic [4:0]  rba_s;
    forever begin
      @(negedge clk);
      ce_s = clock_enable; rst_s = o_rst; dma_s = DM_Addr; rba_s = RB_Addr;
      @(posedge clk);
      #1;
      DM_Data = dm_mem[dma_s[5:2]];
      RB_Data = rb_mem[rba_s];
      if (rst_s === 1'b1) begin
        model_pc = '0;
        rst_count++;
      end else if (ce_s === 1'b1) begin
        ce_count++;
        if (proc_adv) model_pc = model_pc + 32'd4;
      end
      current_PC = model_pc;
      halt_flag  = halt_en && (model_pc == halt_pc);
    end
  end

  // UART transmitter stand-in
  initial begin
    @(negedge clk);
    forever begin
      if (tx_start === 1'b1 && reset === 1'b0) begin
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        tx_busy = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  // Per-cycle scoreboard compare
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        if (IM_We === 1'b1) begin
          if (im_q.size() == 0) begin
            check("im_we_unexpected", 1, 0);
          end else begin
            e = im_q.pop_front();
            check("im_addr", IM_Addr, e[63:32]);
            check("im_data", IM_Data, e[31:0]);
          end
          im_cnt++;
          last_im_addr = IM_Addr;
          last_im_data = IM_Data;
        end
        if (tx_start === 1'b1) begin
          check("ce_during_dump", clock_enable, 0);
          if (tx_q.size() == 0) begin
            check("tx_unexpected", 1, 0);
          end else begin
            check("tx_byte", tx_data, tx_q.pop_front());
          end
          if (tx_sent < 256) tx_log[tx_sent] = tx_data;
          tx_sent++;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] s;
    s = w;
    for (int b = 0; b < 4; b++) begin
      send_byte(s[7:0]);
      s = s >> 8;
    end
  endtask

  task automatic load_word(input logic [31:0] w);
    if (model_idx < IMD) begin
      im_q.push_back({32'(model_idx * 4), w});
      model_idx++;
    end
    send_word(w);
  endtask

  task automatic push_word(input logic [31:0] w);
    logic [31:0] s;
    s = w;
    for (int b = 0; b < 4; b++) begin
      tx_q.push_back(s[7:0]);
      s = s >> 8;
    end
  endtask

  task automatic push_dump(input logic [31:0] pc, input logic [31:0] cc);
    push_word(pc);
    for (int i = 0; i < DMW; i++) push_word(dm_mem[i]);
    for (int i = 0; i < RBR; i++) push_word(rb_mem[i]);
    push_word(cc);
  endtask

  task automatic wait_dump();
    int n;
    n = 0;
    while ((tx_q.size() != 0 || tx_busy) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("dump_complete", tx_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_im();
    repeat (4) @(negedge clk);
    check("im_pending", im_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) dm_mem[i] = '0;
    for (int i = 0; i < 32; i++) rb_mem[i] = 32'h452;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs_held", |{tx_data, tx_start, IM_Addr, IM_Data, IM_We, DM_Addr, RB_Addr, clock_enable, o_rst}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_outputs_after", |{tx_data, tx_start, IM_Addr, IM_Data, IM_We, DM_Addr, RB_Addr, clock_enable, o_rst}, 0);

    // Program load
    im_cnt = 0;
    load_word(32'h000000FF);
    load_word(32'h00000023);
    load_word(32'h00000789);
    load_word(32'hFFFFFFFF);
    wait_im();
    check("load_write_count", im_cnt, 4);
    check("load_last_addr", last_im_addr, 32'd12);
    check("load_last_data", last_im_data, 32'hFFFFFFFF);

    // Single step from PC 2
    model_pc = 32'h2; clock_count = 32'h3; proc_adv = 1'b0;
    ce_count = 0; tx_sent = 0;
    push_dump(32'h2, 32'h3);
    send_word(32'h2);
    wait_dump();
    check("step_ce_cycles", ce_count, 1);
    check("step_bytes_sent", tx_sent, 152);
    check("step_pc_byte0", tx_log[0], 8'h02);
    check("step_rb_byte0", tx_log[20], 8'h52);
    check("step_rb_byte1", tx_log[21], 8'h04);
    check("step_clk_byte0", tx_log[148], 8'h03);

    // Breakpoint at 8, run from PC 0
    for (int i = 0; i < 16; i++) dm_mem[i] = 32'h10000000 + 32'(i) * 32'h11;
    for (int i = 0; i < 32; i++) rb_mem[i] = 32'hA5000000 | (32'(i) * 32'h00010203);
    model_pc = '0; proc_adv = 1'b1; clock_count = 32'h55;
    send_word(32'h3);
    send_word(32'h8);
    ce_count = 0; tx_sent = 0;
    push_dump(32'h8, 32'h55);
    send_word(32'h1);
    wait_dump();
    check("bp_ce_cycles", ce_count, 2);
    check("bp_stop_pc", model_pc, 32'h8);

    // Resume from the breakpoint; HALT reached after 4 advances
    halt_pc = 32'd24; halt_en = 1'b1; clock_count = 32'h1234;
    ce_count = 0; rst_count = 0;
    push_dump(32'd24, 32'h1234);
    send_word(32'h1);
    wait_dump();
    check("halt_ce_cycles", ce_count, 4);
    check("halt_o_rst", rst_count, 1);
    check("halt_pc_reset", model_pc, 0);

    // Overfill instruction memory
    halt_en = 1'b0; model_idx = 0; im_cnt = 0;
    for (int i = 0; i < IMD + 2; i++) load_word(32'h100 + 32'(i));
    load_word(32'hFFFFFFFF);
    wait_im();
    check("depth_write_count", im_cnt, IMD);
    check("depth_last_addr", last_im_addr, 32'(4 * (IMD - 1)));

    // Reload command restarts the write index
    send_word(32'h4);
    repeat (4) @(negedge clk);
    check("reload_o_rst", rst_count, 2);
    model_idx = 0; im_cnt = 0;
    load_word(32'hABCD0001);
    load_word(32'hFFFFFFFF);
    wait_im();
    check("reload_write_count", im_cnt, 2);
    check("reload_last_addr", last_im_addr, 32'd4);

    // Disarmed breakpoint: run passes PC 8 and halts at 12
    send_word(32'h3);
    send_word(32'hFFFFFFFF);
    model_pc = '0; halt_pc = 32'd12; halt_en = 1'b1; clock_count = 32'h77;
    ce_count = 0;
    push_dump(32'd12, 32'h77);
    send_word(32'h1);
    wait_dump();
    check("disarm_ce_cycles", ce_count, 3);
    check("disarm_o_rst", rst_count, 3);

    // Reset in the middle of a dump
    halt_en = 1'b0; model_idx = 0;
    load_word(32'hFFFFFFFF);
    wait_im();
    proc_adv = 1'b0; tx_sent = 0;
    push_dump(32'h0, 32'h77);
    send_word(32'h2);
    n = 0;
    while (tx_sent < 6 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_dump_reached", tx_sent >= 6, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", |{tx_data, tx_start, IM_Addr, IM_Data, IM_We, DM_Addr, RB_Addr, clock_enable, o_rst}, 0);
    tx_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_idx = 0; im_cnt = 0;
    load_word(32'h12345678);
    wait_im();
    check("post_reset_addr", last_im_addr, 0);
    check("post_reset_data", last_im_data, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/debug_controller_bp.md
Name: debug_controller_bp

Overview:
Second-generation debug controller between the byte-wide UART and the pipelined processor.
- Loads a program into instruction memory from byte-serial words.
- Accepts run, step, breakpoint and reload commands.
- Gates the processor clock enable.
- Dumps PC, data memory, register bank and cycle count back over UART, all word counts parametrised.

Parameters:
NBITS, 32, word width; multiple of UART_BITS.
UART_BITS, 8, UART data width.
IM_ADDR_LENGTH, 32, IM byte-address width.
IM_DEPTH, 32, IM capacity in words.
DM_ADDR_LENGTH, 32, DM byte-address width.
DM_WORDS, 4, DM words dumped.
RBITS, 5, register address width.
RB_REGS, 32, registers dumped.
HALT_WORD, 32'hFFFFFFFF, end-of-program sentinel (HALT opcode).
CMD_RUN, 32'h1; CMD_STEP, 32'h2; CMD_BP, 32'h3; CMD_RELOAD, 32'h4: command words.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
rx_data  in  UART_BITS  received byte.
rx_done  in  1  one-cycle pulse: rx_data valid.
tx_done  in  1  one-cycle pulse: UART finished the byte.
halt_flag  in  1  processor executed HALT.
current_PC  in  NBITS  processor PC.
clock_count  in  NBITS  processor cycle counter.
DM_Data  in  NBITS  DM read data; synchronous, valid 1 cycle after DM_Addr.
RB_Data  in  NBITS  RB read data; synchronous, valid 1 cycle after RB_Addr.
tx_data  out  UART_BITS  byte to send.
tx_start  out  1  one-cycle send pulse.
IM_Addr  out  IM_ADDR_LENGTH  IM write byte address.
IM_Data  out  NBITS  IM write word.
IM_We  out  1  IM write enable, one-cycle pulse.
DM_Addr  out  DM_ADDR_LENGTH  DM dump address.
RB_Addr  out  RBITS  RB dump address.
clock_enable  out  1  processor advance enable.
o_rst  out  1  processor reset, one-cycle pulse.

Behaviour:
Reset values:
- State RECV_PROG.
- All outputs 0.
- Breakpoint disarmed; word assembler and write index cleared.

Word assembly:
- rx bytes are packed LSB-first.
- Word is complete on the (NBITS/UART_BITS)-th rx_done.
- The completion cycle is the "word strobe".
- Reset mid-word discards the partial word.

RECV_PROG:
- Each word strobe drives IM_Data=word, IM_Addr=4*index, IM_We=1 on the next cycle; then index++.
- Writes when index>=IM_DEPTH are suppressed and the index holds.
- HALT_WORD is itself written (if in range).
- After HALT_WORD: go to RECV_CMD.

RECV_CMD (on word strobe):
- CMD_RUN -> RUN.
- CMD_STEP -> STEP.
- CMD_BP -> RECV_BP.
- CMD_RELOAD -> pulse o_rst, clear index, -> RECV_PROG.
- Any other word: ignored, stay.

RECV_BP:
- Next word becomes bp_addr; bp_en=1; -> RECV_CMD.
- A bp_addr of HALT_WORD disarms the breakpoint.

RUN:
- clock_enable = ~halt_flag & ~bp_hit (combinational).
- bp_hit = bp_en & (current_PC==bp_addr) & ~first_cycle.
- first_cycle masks a hit in the first RUN cycle so execution can resume from the breakpoint PC.
- On halt_flag or bp_hit -> DUMP_PC.
- The processor never advances past the stop condition.

STEP:
- clock_enable=1 for exactly one cycle (0 if halt_flag already set).
- Then -> DUMP_PC.

Dump sequence:
- Order: DUMP_PC (current_PC), DUMP_DM (DM_Addr=0,4,..,4*(DM_WORDS-1)), DUMP_RB (RB_Addr=0..RB_REGS-1), DUMP_CLK (clock_count).
- Each word: address set, 1 wait cycle, word latched, then serialized LSB byte first.
- Per byte: tx_start pulse, wait tx_done, next byte starts the cycle after tx_done.
- rx_done is ignored during dump.
- clock_enable=0 throughout.

After DUMP_CLK:
- If halt_flag was set at dump entry: pulse o_rst, clear index -> RECV_PROG.
- Otherwise -> RECV_CMD.

Simultaneous events:
- halt_flag and bp_hit together are treated as halt.
- tx_done with no outstanding tx_start is ignored.

Test Plan:
- Load 0x000000FF, 0x00000023, 0x00000789, 0xFFFFFFFF as 16 bytes -> IM_We pulses at IM_Addr 0,4,8,12 with those words; state RECV_CMD.
- CMD_STEP with current_PC=0x2, DM all 0x0, RB all 0x452, clock_count=0x3 -> clock_enable high 1 cycle; tx bytes 02 00 00 00, then DM_WORDS×4 zero bytes, RB_REGS×(52 04 00 00), then 03 00 00 00; returns to RECV_CMD.
- CMD_BP with 0x00000008, then CMD_RUN, PC stepping 0,4,8 -> clock_enable drops combinationally in the cycle current_PC==8; dump sent; second CMD_RUN at PC 8 advances the processor.
- CMD_RUN, halt_flag rises after 4 cycles -> clock_enable 0 the same cycle; full dump; o_rst pulse; state RECV_PROG.
- IM_DEPTH+2 words before HALT_WORD -> only IM_DEPTH IM_We pulses.
- Reset asserted mid-byte-serialization -> all outputs 0 immediately; next rx word is written at IM_Addr 0.
